// File: rtl/keypad_scan_entry_if.sv
// Keypad scanner bundle: matrix row/column lines plus the key-event / BCD entry outputs.
interface keypad_scan_entry_if;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] entry;
    logic        entry_done;

    // master: the scanner itself (drives rows, reports keys)
    modport master (
        input  col_in,
        output row_out, key_code, key_valid, key_held, entry, entry_done
    );

    // slave: the keypad / consumer side
    modport slave (
        output col_in,
        input  row_out, key_code, key_valid, key_held, entry, entry_done
    );
endinterface

// File: rtl/keypad_scan_entry.sv
// 4x4 active-low matrix keypad scanner with frame-level debounce, a press FSM
// and a 4-digit BCD entry register ('*' clears, '#' completes).
module keypad_scan_entry #(
    parameter int SCAN_TICKS     = 50_000,
    parameter int DEBOUNCE_SCANS = 20
) (
    input  logic                   CLK_50M,
    input  logic                   RSTn,
    keypad_scan_entry_if.master    kp
);
    localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_LOCKED} state_t;

    logic [TW-1:0] r_tick;
    logic [1:0]    r_row;
    logic [15:0]   r_snap;
    logic [15:0]   r_prev;
    logic [CW-1:0] r_stable;
    state_t        r_state;
    logic [15:0]   r_key_pat;
    logic [3:0]    r_key_code;
    logic          r_key_valid;
    logic [15:0]   r_entry;
    logic          r_entry_done;

    logic          w_tick_end;
    logic          w_frame_end;
    logic [15:0]   w_snap_next;
    logic [CW-1:0] w_stable_next;
    logic          w_p_upd;
    logic          w_onehot;
    logic [3:0]    w_idx;
    logic [3:0]    w_code;
    logic          w_fire;
    state_t        w_state_next;

    // Key legend, indexed by 4*row + col
    function automatic logic [3:0] key_map(input logic [3:0] idx);
        case (idx)
            4'd0:  key_map = 4'd1;
            4'd1:  key_map = 4'd2;
            4'd2:  key_map = 4'd3;
            4'd3:  key_map = 4'd10;
            4'd4:  key_map = 4'd4;
            4'd5:  key_map = 4'd5;
            4'd6:  key_map = 4'd6;
            4'd7:  key_map = 4'd11;
            4'd8:  key_map = 4'd7;
            4'd9:  key_map = 4'd8;
            4'd10: key_map = 4'd9;
            4'd11: key_map = 4'd12;
            4'd12: key_map = 4'd14;
            4'd13: key_map = 4'd0;
            4'd14: key_map = 4'd15;
            default: key_map = 4'd13;
        endcase
    endfunction

    assign w_tick_end  = (r_tick == TW'(SCAN_TICKS - 1));
    assign w_frame_end = w_tick_end && (r_row == 2'd3);

    // Snapshot including the row being sampled this cycle; the FSM looks at
    // the completed frame on the same edge that closes it.
    always_comb begin
        w_snap_next = r_snap;
        if (w_tick_end)
            w_snap_next[{r_row, 2'b00} +: 4] = ~kp.col_in;
    end

    // Frame-to-frame stability count, saturating at the debounce threshold
    always_comb begin
        if (w_snap_next != r_prev)
            w_stable_next = '0;
        else if (r_stable == CW'(DEBOUNCE_SCANS))
            w_stable_next = r_stable;
        else
            w_stable_next = r_stable + 1'b1;
    end

    assign w_p_upd  = w_frame_end && (w_stable_next == CW'(DEBOUNCE_SCANS));
    assign w_onehot = (w_snap_next != 16'd0) && ((w_snap_next & (w_snap_next - 16'd1)) == 16'd0);

    // Position of the (single) pressed key in the pattern
    always_comb begin
        w_idx = 4'd0;
        for (int i = 0; i < 16; i++)
            if (w_snap_next[i]) w_idx = 4'(i);
    end
    assign w_code = key_map(w_idx);

    // Row rotation, column sampling and debounce bookkeeping
    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) begin
            r_tick   <= '0;
            r_row    <= 2'd0;
            r_snap   <= '0;
            r_prev   <= '0;
            r_stable <= '0;
        end else begin
            if (w_tick_end) begin
                r_tick <= '0;
                r_row  <= r_row + 2'd1;
                r_snap <= w_snap_next;
            end else begin
                r_tick <= r_tick + 1'b1;
            end
            if (w_frame_end) begin
                r_prev   <= w_snap_next;
                r_stable <= w_stable_next;
            end
        end
    end

    // FSM state register
    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // FSM next state; only a one-hot pattern from IDLE produces an event
    always_comb begin
        w_state_next = r_state;
        w_fire       = 1'b0;
        if (w_p_upd) begin
            case (r_state)
                S_IDLE: begin
                    if (w_onehot) begin
                        w_state_next = S_PRESSED;
                        w_fire       = 1'b1;
                    end else if (w_snap_next != 16'd0) begin
                        w_state_next = S_LOCKED;
                    end
                end
                S_PRESSED: begin
                    if (w_snap_next == 16'd0)           w_state_next = S_IDLE;
                    else if (w_snap_next != r_key_pat)  w_state_next = S_LOCKED;
                end
                default: begin
                    if (w_snap_next == 16'd0) w_state_next = S_IDLE;
                end
            endcase
        end
    end

    // Event outputs and BCD entry assembly
    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) begin
            r_key_pat    <= '0;
            r_key_code   <= '0;
            r_key_valid  <= 1'b0;
            r_entry      <= '0;
            r_entry_done <= 1'b0;
        end else begin
            r_key_valid  <= w_fire;
            r_entry_done <= w_fire && (w_code == 4'd15);
            if (w_fire) begin
                r_key_pat  <= w_snap_next;
                r_key_code <= w_code;
                if (w_code <= 4'd9)
                    r_entry <= {r_entry[11:0], w_code};
                else if (w_code == 4'd14)
                    r_entry <= '0;
            end
        end
    end

    assign kp.row_out    = ~(4'b0001 << r_row);
    assign kp.key_code   = r_key_code;
    assign kp.key_valid  = r_key_valid;
    assign kp.key_held   = (r_state == S_PRESSED);
    assign kp.entry      = r_entry;
    assign kp.entry_done = r_entry_done;
endmodule

// File: tb/tb_keypad_scan_entry.sv
// Bench for keypad_scan_entry: matrix model, event scoreboard, table of key presses
// plus hand-written bounce / lock / reset-mid-press sequences.
module tb_keypad_scan_entry;
    localparam int ST = 4;
    localparam int DB = 2;
    localparam int SETTLE = 96;

    logic CLK_50M = 1'b0;
    logic RSTn    = 1'b0;
    logic [15:0] keys = '0;

    keypad_scan_entry_if kp();

    keypad_scan_entry #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(DB)) dut (
        .CLK_50M (CLK_50M),
        .RSTn    (RSTn),
        .kp      (kp)
    );

    always #5 CLK_50M = ~CLK_50M;

    // Keypad matrix: a driven (low) row pulls down the columns of its pressed keys
    always_comb begin
        logic [3:0] cols;
        cols = '0;
        for (int r = 0; r < 4; r++)
            if (!kp.row_out[r]) cols = cols | keys[r*4 +: 4];
        kp.col_in = ~cols;
    end

    typedef struct {
        logic [3:0]  code;
        logic [15:0] entry;
        logic        done;
    } ev_t;

    typedef struct {
        int          key;
        logic [3:0]  code;
        logic [15:0] entry;
        logic        done;
    } vec_t;

    ev_t  q[$];
    vec_t tbl[13];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [15:0] m_entry = '0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard side: every key_valid pulse must match the oldest expected event
    task automatic mon();
        ev_t e;
        if (kp.key_valid === 1'b1) begin
            if (q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_event: got code %h entry %h expected none", kp.key_code, kp.entry);
            end else begin
                e = q.pop_front();
                chk("ev_code",  {12'd0, kp.key_code},   {12'd0, e.code});
                chk("ev_entry", kp.entry,               e.entry);
                chk("ev_done",  {15'd0, kp.entry_done}, {15'd0, e.done});
            end
        end else if (kp.entry_done === 1'b1) begin
            n_cmp++; n_bad++;
            $display("FAIL stray_done: got 1 expected 0");
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge CLK_50M);
            mon();
        end
    endtask

    function automatic logic [15:0] nxt(input logic [15:0] en, input logic [3:0] code);
        if (code <= 4'd9)       nxt = {en[11:0], code};
        else if (code == 4'd14) nxt = 16'd0;
        else                    nxt = en;
    endfunction

    task automatic expect_key(input logic [3:0] code);
        ev_t e;
        e.code  = code;
        e.entry = nxt(m_entry, code);
        e.done  = (code == 4'd15);
        m_entry = e.entry;
        q.push_back(e);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_row"},   {12'd0, kp.row_out},    16'h000e);
        chk({tag, "_code"},  {12'd0, kp.key_code},   16'h0000);
        chk({tag, "_valid"}, {15'd0, kp.key_valid},  16'h0000);
        chk({tag, "_held"},  {15'd0, kp.key_held},   16'h0000);
        chk({tag, "_entry"}, kp.entry,               16'h0000);
        chk({tag, "_done"},  {15'd0, kp.entry_done}, 16'h0000);
    endtask

    task automatic press_release(input int key, input string tag);
        keys = 16'd1 << key;
        step(SETTLE);
        chk({tag, "_held"},    {15'd0, kp.key_held}, 16'h0001);
        chk({tag, "_pending"}, 16'(q.size()),        16'h0000);
        keys = '0;
        step(SETTLE);
        chk({tag, "_released"}, {15'd0, kp.key_held}, 16'h0000);
    endtask

    initial begin
        ev_t e;
        // key index (4*row+col), code, entry after event, done
        tbl[0]  = '{5,  4'd5,  16'h0005, 1'b0};
        tbl[1]  = '{0,  4'd1,  16'h0051, 1'b0};
        tbl[2]  = '{1,  4'd2,  16'h0512, 1'b0};
        tbl[3]  = '{2,  4'd3,  16'h5123, 1'b0};
        tbl[4]  = '{4,  4'd4,  16'h1234, 1'b0};
        tbl[5]  = '{5,  4'd5,  16'h2345, 1'b0};
        tbl[6]  = '{12, 4'd14, 16'h0000, 1'b0};
        tbl[7]  = '{8,  4'd7,  16'h0007, 1'b0};
        tbl[8]  = '{10, 4'd9,  16'h0079, 1'b0};
        tbl[9]  = '{14, 4'd15, 16'h0079, 1'b1};
        tbl[10] = '{3,  4'd10, 16'h0079, 1'b0};
        tbl[11] = '{13, 4'd0,  16'h0790, 1'b0};
        tbl[12] = '{15, 4'd13, 16'h0790, 1'b0};

        // Reset state
        step(3);
        chk_reset_vals("rst");
        RSTn = 1'b1;

        // Row scan with no keys: one row per ST clocks
        for (int n = 0; n < 32; n++) begin
            chk("row_scan", {12'd0, kp.row_out}, {12'd0, ~(4'b0001 << ((n / ST) % 4))});
            step(1);
        end
        step(64);

        // Table-driven presses through the entry path
        for (int i = 0; i < 13; i++) begin
            e.code  = tbl[i].code;
            e.entry = tbl[i].entry;
            e.done  = tbl[i].done;
            q.push_back(e);
            press_release(tbl[i].key, "tbl");
            chk("tbl_code_hold", {12'd0, kp.key_code}, {12'd0, tbl[i].code});
            chk("tbl_entry",     kp.entry,             tbl[i].entry);
            m_entry = tbl[i].entry;
        end

        // Bounce: r0c0 toggles every frame, then held
        for (int i = 0; i < 3; i++) begin
            keys = 16'h0001; step(ST * 4);
            keys = 16'h0000; step(ST * 4);
        end
        chk("bounce_held", {15'd0, kp.key_held}, 16'h0000);
        expect_key(4'd1);
        press_release(0, "bounce");

        // Two keys together lock out; then a clean '3'
        keys = 16'h0003;
        step(128);
        chk("lock_held", {15'd0, kp.key_held}, 16'h0000);
        keys = '0;
        step(SETTLE);
        expect_key(4'd3);
        press_release(2, "after_lock");
        chk("after_lock_code", {12'd0, kp.key_code}, 16'h0003);

        // Second key joining a held key: no event, leaves PRESSED
        expect_key(4'd5);
        keys = 16'h0020;
        step(SETTLE);
        chk("join_held", {15'd0, kp.key_held}, 16'h0001);
        keys = 16'h0060;
        step(SETTLE);
        chk("join_locked", {15'd0, kp.key_held}, 16'h0000);
        keys = '0;
        step(SETTLE);

        // Reset in the middle of a held '4'
        expect_key(4'd4);
        keys = 16'h0010;
        step(SETTLE);
        chk("pre_rst_pending", 16'(q.size()), 16'h0000);
        RSTn = 1'b0;
        #1;
        chk_reset_vals("midrst");
        step(3);
        RSTn = 1'b1;
        m_entry = '0;
        expect_key(4'd4);
        step(SETTLE);
        chk("midrst_held",    {15'd0, kp.key_held}, 16'h0001);
        chk("midrst_pending", 16'(q.size()),        16'h0000);
        keys = '0;
        step(SETTLE);
        chk("midrst_entry",   kp.entry,             16'h0004);
        chk("final_pending",  16'(q.size()),        16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
